// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and the MEM stage.
// Data wins by default; a starvation counter hands priority to fetch after STARVE_LIMIT denials.
//
// owner state | meaning
// ------------+------------------------------------------------------------
// OWN_NONE    | no read in flight (idle, store, or just out of reset)
// OWN_IF      | fetch read granted last cycle, if_rvalid this cycle
// OWN_DATA    | data load granted last cycle, d_rvalid this cycle
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       fetch_pri;

  assign fetch_pri = (starve_cnt == LIMIT);

  // Grants are gated by reset so nothing reaches the memory while rst is low.
  assign if_gnt = rst & if_req & (~d_req | fetch_pri);
  assign d_gnt  = rst & d_req & ~(if_req & fetch_pri);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_WIDTH+1:2];
      mem_be   = 4'b1111;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr[ADDR_WIDTH+1:2];
      mem_wdata = d_wdata;
      mem_be    = d_we ? d_be : 4'b1111;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      if (if_gnt)
        owner <= OWN_IF;
      else if (d_gnt && !d_we)
        owner <= OWN_DATA;
      else
        owner <= OWN_NONE;

      if (if_gnt)
        starve_cnt <= 4'd0;
      else if (if_req && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign if_rvalid = (owner == OWN_IF);
  assign d_rvalid  = (owner == OWN_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign d_rdata   = d_rvalid  ? mem_rdata : 32'd0;

  // Address bits outside the word index alias onto the same memory word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                              d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width of the shared single-port memory.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive fetch denials before fetch gets priority (legal 1..15).
REQ-003 clk  in  1  single clock, all state rising-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch read request.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch read data valid.
REQ-009 if_rdata  out  32  fetch read data.
REQ-010 d_req  in  1  MEM-stage request (load or store).
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_be  in  4  store byte enables.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_rvalid  out  1  load data valid.
REQ-017 d_rdata  out  32  load data.
REQ-018 mem_en  out  1  memory access strobe.
REQ-019 mem_we  out  1  memory write strobe.
REQ-020 mem_addr  out  ADDR_WIDTH  memory word address.
REQ-021 mem_wdata  out  32  memory write data.
REQ-022 mem_be  out  4  memory byte enables.
REQ-023 mem_rdata  in  32  memory read data, valid one cycle after a read strobe.

Function
REQ-024 Grants SHALL be combinational in the request cycle; at most one of if_gnt/d_gnt SHALL be high per cycle.
REQ-025 Default priority: data over fetch; d_req alone -> d_gnt; if_req alone -> if_gnt.
REQ-026 starve_cnt (4 bits) SHALL increment on each cycle with if_req=1 and if_gnt=0, saturate at STARVE_LIMIT, and clear on if_gnt.
REQ-027 When starve_cnt == STARVE_LIMIT and both requests are present, fetch SHALL win; data is denied that cycle.
REQ-028 The granted request SHALL drive the memory in the same cycle: mem_en=1, mem_addr = addr[ADDR_WIDTH+1:2], upper address bits ignored (aliasing), byte offset bits ignored.
REQ-029 Fetch grant: mem_we=0, mem_be=4'b1111. Data grant: mem_we=d_we, mem_be = d_we ? d_be : 4'b1111, mem_wdata=d_wdata.
REQ-030 With no grant: mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-031 Registered owner state {NONE, IF, DATA} SHALL record each granted read; next cycle the matching rvalid SHALL pulse for exactly one cycle with rdata=mem_rdata.
REQ-032 Stores SHALL produce no rvalid; owner becomes NONE.
REQ-033 Back-to-back reads SHALL be fully pipelined: one grant per cycle, rvalid stream in grant order, no bubble.
REQ-034 if_rdata/d_rdata SHALL be 0 whenever their rvalid is 0.
REQ-035 Requesters hold req/addr/data stable until granted; the arbiter SHALL not latch ungranted requests.

Reset
REQ-036 rst=0 SHALL asynchronously clear starve_cnt to 0 and owner to NONE; all rvalid outputs 0 immediately.
REQ-037 During reset, if_gnt=d_gnt=0 and mem_en=mem_we=0 regardless of requests.
REQ-038 A read granted in the cycle reset asserts SHALL return no rvalid after reset release.
REQ-039 First grant is possible in the first clock edge after rst deasserts.

Verification
REQ-040 if_req=1, if_addr=0x10, d_req=0 -> if_gnt=1, mem_addr=4, mem_en=1; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-041 Both request 6 cycles, d_we=0, STARVE_LIMIT=4 -> d_gnt cycles 0-3, if_gnt cycle 4, d_gnt cycle 5; starve_cnt back to 0 after cycle 4.
REQ-042 d_req=1, d_we=1, d_addr=0x24, d_be=4'b0011, d_wdata=0xA5A5_1234 -> mem_we=1, mem_addr=9, mem_be=0011; no d_rvalid following.
REQ-043 Alternating data read/fetch grants over 4 consecutive cycles -> rvalids delivered in the same order, one per cycle, to the correct port.
REQ-044 Read granted, rst pulsed low mid-cycle -> if_rvalid and d_rvalid stay 0 through and after release; starve_cnt=0.
REQ-045 if_addr=0xFFFF_F004 -> mem_addr=1 (upper bits ignored).
